dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-ported data memory (behind the DMemController) between the CPU load/store path and a second bus master (debug loader / DMA). Each requester raises a word request with index, write flag and data, and receives a one-cycle grant pulse. Reads also return a one-cycle read-valid pulse with data. The block sequences each access through a small FSM so that exactly one memory command is issued at a time, and it drives the memory's write-enable, index and write-data inputs.

---
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// DMemArbiter (module dmem_arbiter)
//
// Shares the single-ported data memory between two bus masters:
// port 0 is the CPU load/store path and port 1 is the debug loader or DMA.
// Each access goes through a small FSM (IDLE -> CMD [-> WAIT -> RESP]).
// The FSM ensures that only one memory command is in flight at a time.
//
// Optional build macro:
//   DMEM_ARB_RR_EN  defined   : round-robin tie-break. Ties go to the port
//                               that was not granted most recently.
//                   undefined : fixed priority. Port 0 wins every tie.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous, active-low reset
//   req0/req1            access request per port (sampled in IDLE only)
//   wr0/wr1              1 = write, 0 = read
//   idx0/idx1            word index
//   wdata0/wdata1        write data
//   gnt0/gnt1            one-cycle pulse, request accepted (CMD cycle)
//   rvalid0/rvalid1      one-cycle pulse, rdata holds the read result
//   rdata                shared read result, held until the next capture
//   dMemWrtEn            memory write enable
//   dMemIndex            memory word index
//   dMemIn               memory write data
//   dMemOut              memory read data, valid the cycle after the index
//   busy                 high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DBITS        = 32,
   parameter int DMEMADDRBITS = 13,
   parameter int DMEMWORDBITS = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 req0,
   input  logic                                 req1,
   input  logic                                 wr0,
   input  logic                                 wr1,
   input  logic [DMEMADDRBITS-DMEMWORDBITS-1:0] idx0,
   input  logic [DMEMADDRBITS-DMEMWORDBITS-1:0] idx1,
   input  logic [DBITS-1:0]                     wdata0,
   input  logic [DBITS-1:0]                     wdata1,
   output logic                                 gnt0,
   output logic                                 gnt1,
   output logic                                 rvalid0,
   output logic                                 rvalid1,
   output logic [DBITS-1:0]                     rdata,
   output logic                                 dMemWrtEn,
   output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] dMemIndex,
   output logic [DBITS-1:0]                     dMemIn,
   input  logic [DBITS-1:0]                     dMemOut,
   output logic                                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } stateT;

   stateT state;
   stateT nextState;

   logic  anyReq;
   logic  winner;
   logic  portId;
   logic  wrReg;

   assign anyReq = req0 | req1;

`ifdef DMEM_ARB_RR_EN
   logic lastGnt;

   // Round-robin pick. On a tie, the port that did not win last time gets
   // the grant. A lone requester always wins.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
         winner = ~lastGnt;
      end else begin
         winner = ~req0;
      end
   end

   // Remember which port won most recently. The reset value of 1 makes
   // port 0 the winner of the first tie after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lastGnt <= 1'b1;
      end else if (state == IDLE && anyReq) begin
         lastGnt <= winner;
      end
   end
`else
   // Fixed priority. Port 1 wins only when port 0 is not requesting.
   always_comb begin
      winner = ~req0;
   end
`endif

   // State register. An asynchronous reset drops any transaction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A write finishes right after its command cycle.
   // A read waits one cycle for the synchronous memory and then presents
   // the result for one cycle.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (anyReq) nextState = CMD;
         CMD:     nextState = wrReg ? IDLE : WAIT;
         WAIT:    nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Capture the winning request when leaving IDLE. The memory index and
   // write-data outputs come straight from these registers, so they keep
   // their last value while the FSM idles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         portId    <= 1'b0;
         wrReg     <= 1'b0;
         dMemIndex <= '0;
         dMemIn    <= '0;
      end else if (state == IDLE && anyReq) begin
         portId    <= winner;
         wrReg     <= winner ? wr1 : wr0;
         dMemIndex <= winner ? idx1 : idx0;
         dMemIn    <= winner ? wdata1 : wdata0;
      end
   end

   // Read data arrives from memory during WAIT and is stored at the end of
   // that cycle. It stays put until the next read, so it is stable in RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (state == WAIT) begin
         rdata <= dMemOut;
      end
   end

   // All handshake and memory-control outputs are decoded from registered
   // state only. This keeps any request input from reaching an output
   // through combinational logic.
   always_comb begin
      gnt0      = (state == CMD)  && !portId;
      gnt1      = (state == CMD)  &&  portId;
      rvalid0   = (state == RESP) && !portId;
      rvalid1   = (state == RESP) &&  portId;
      dMemWrtEn = (state == CMD)  &&  wrReg;
      busy      = (state != IDLE);
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for dmem_arbiter.
//
// A behavioural synchronous RAM stands in for the data memory. Stimulus
// tasks push the expected grant order and read data into queues. A monitor
// pops from those queues and compares whenever a grant or read-valid pulse
// appears.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int DBITS = 32;
   localparam int IW    = 11;

   logic             clk   = 1'b0;
   logic             reset = 1'b0;
   logic             req0, req1, wr0, wr1;
   logic [IW-1:0]    idx0, idx1;
   logic [DBITS-1:0] wdata0, wdata1;
   logic             gnt0, gnt1, rvalid0, rvalid1, dMemWrtEn, busy;
   logic [DBITS-1:0] rdata, dMemIn, dMemOut;
   logic [IW-1:0]    dMemIndex;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int               expGnt[$];
   logic [DBITS-1:0] expRd0[$];
   logic [DBITS-1:0] expRd1[$];
   logic [DBITS-1:0] refMem [0:2047];
   logic [DBITS-1:0] memModel [0:2047];
   int               lastRvCyc [0:1];

   int g, raiseCyc, prevG, g0a, g0b, g1a, g1b, gA, gB, tmpC;

   dmem_arbiter #(.DBITS(32), .DMEMADDRBITS(13), .DMEMWORDBITS(2)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .idx0(idx0), .idx1(idx1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .dMemWrtEn(dMemWrtEn), .dMemIndex(dMemIndex),
      .dMemIn(dMemIn), .dMemOut(dMemOut), .busy(busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Cycle counter used to measure grant and read-valid latencies.
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port memory. Reads return data one cycle after the
   // index is presented.
   always @(posedge clk) begin
      if (dMemWrtEn) memModel[dMemIndex] <= dMemIn;
      dMemOut <= memModel[dMemIndex];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] idleWord();
      return rdata | dMemIn | {21'b0, dMemIndex} |
             {26'b0, gnt0, gnt1, rvalid0, rvalid1, dMemWrtEn, busy};
   endfunction

   // Monitor. Grants and read-valid pulses are compared against the
   // scoreboard queues. It also checks that the one-hot properties hold and
   // that a write enable only appears together with a grant.
   always @(negedge clk) begin
      if (reset) begin
         if (gnt0 || gnt1) begin
            checkOutput("gntExclusive", {31'b0, gnt0 & gnt1}, 32'd0);
            checkOutput("gntWithRvalid", {31'b0, rvalid0 | rvalid1}, 32'd0);
            if (expGnt.size() == 0) begin
               total++; bad++;
               $display("[TB] FAIL gntUnexpected: actual gnt1=%0b required no grant", gnt1);
            end else begin
               checkOutput("gntPort", {31'b0, gnt1}, expGnt.pop_front());
            end
         end
         if (rvalid0 || rvalid1) begin
            checkOutput("rvalidExclusive", {31'b0, rvalid0 & rvalid1}, 32'd0);
            if (rvalid0) begin
               lastRvCyc[0] = cyc;
               if (expRd0.size() == 0) begin
                  total++; bad++;
                  $display("[TB] FAIL rvalid0Unexpected: actual rdata=0x%08h required no pulse", rdata);
               end else begin
                  checkOutput("rdata0", rdata, expRd0.pop_front());
               end
            end
            if (rvalid1) begin
               lastRvCyc[1] = cyc;
               if (expRd1.size() == 0) begin
                  total++; bad++;
                  $display("[TB] FAIL rvalid1Unexpected: actual rdata=0x%08h required no pulse", rdata);
               end else begin
                  checkOutput("rdata1", rdata, expRd1.pop_front());
               end
            end
         end
         if (dMemWrtEn) checkOutput("wrEnOnlyWithGnt", {31'b0, gnt0 | gnt1}, 32'd1);
      end
   end

   task automatic waitGnt(input int port, output int gntCyc);
      gntCyc = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if ((port == 0 && gnt0) || (port == 1 && gnt1)) begin
            gntCyc = cyc;
            break;
         end
      end
      if (gntCyc < 0) begin
         total++; bad++;
         $display("[TB] FAIL gntTimeout: actual no gnt%0d within 60 cycles required a grant", port);
      end
   endtask

   task automatic waitIdle();
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         total++; bad++;
         $display("[TB] FAIL idleTimeout: actual busy=1 required busy=0 within 20 cycles");
      end
   endtask

   // Raise one request and hold it until the grant is seen, then drop it.
   // Expectations are pushed first. The memory command is checked in the
   // grant cycle.
   task automatic applyStimulus(input int port, input logic wr, input logic [IW-1:0] idx,
                                input logic [31:0] data, input bit pushGnt,
                                output int gntCyc);
      if (pushGnt) expGnt.push_back(port);
      if (wr) refMem[idx] = data;
      else if (port == 0) expRd0.push_back(refMem[idx]);
      else expRd1.push_back(refMem[idx]);
      if (port == 0) begin
         req0 = 1'b1; wr0 = wr; idx0 = idx; wdata0 = data;
      end else begin
         req1 = 1'b1; wr1 = wr; idx1 = idx; wdata1 = data;
      end
      waitGnt(port, gntCyc);
      if (gntCyc >= 0) begin
         checkOutput("wrEnAtGnt", {31'b0, dMemWrtEn}, {31'b0, wr});
         checkOutput("idxAtGnt", {21'b0, dMemIndex}, {21'b0, idx});
         if (wr) checkOutput("dinAtGnt", dMemIn, data);
      end
      if (port == 0) req0 = 1'b0;
      else req1 = 1'b0;
   endtask

   initial begin
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
      idx0 = '0; idx1 = '0; wdata0 = '0; wdata1 = '0;
      lastRvCyc[0] = -1; lastRvCyc[1] = -1;

      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Idle after reset: every output is zero.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("resetIdle", idleWord(), 32'd0);
      end

      // Write then read back on port 0.
      raiseCyc = cyc;
      applyStimulus(0, 1'b1, 11'd5, 32'hDEADBEEF, 1'b1, g);
      checkOutput("wrGntLatency", g - raiseCyc, 32'd1);
      applyStimulus(0, 1'b0, 11'd5, 32'd0, 1'b1, g);
      waitIdle();
      checkOutput("rdLatency", lastRvCyc[0] - g, 32'd2);

      // Seed idx1/idx2. Port 1 is granted last, so port 0 wins the next tie.
      applyStimulus(0, 1'b1, 11'd1, 32'h11111111, 1'b1, g);
      applyStimulus(1, 1'b1, 11'd2, 32'h22222222, 1'b1, g);
      waitIdle();

      // Both ports request continuously.
`ifdef DMEM_ARB_RR_EN
      expGnt.push_back(0); expGnt.push_back(1); expGnt.push_back(0); expGnt.push_back(1);
`else
      expGnt.push_back(0); expGnt.push_back(0); expGnt.push_back(1); expGnt.push_back(1);
`endif
      fork
         begin
            applyStimulus(0, 1'b0, 11'd1, 32'd0, 1'b0, g0a);
            applyStimulus(0, 1'b0, 11'd1, 32'd0, 1'b0, g0b);
         end
         begin
            applyStimulus(1, 1'b0, 11'd2, 32'd0, 1'b0, g1a);
            applyStimulus(1, 1'b0, 11'd2, 32'd0, 1'b0, g1b);
         end
      join
      waitIdle();
`ifdef DMEM_ARB_RR_EN
      checkOutput("tieGap01", g1a - g0a, 32'd4);
      checkOutput("tieGap10", g0b - g1a, 32'd4);
`else
      checkOutput("prioGap00", g0b - g0a, 32'd4);
      checkOutput("prioGap01", g1a - g0b, 32'd4);
`endif

      // Port 1 raises its request during the command of a port-0 read.
      fork
         applyStimulus(0, 1'b0, 11'd2, 32'd0, 1'b1, gA);
         begin
            waitGnt(0, tmpC);
            applyStimulus(1, 1'b0, 11'd1, 32'd0, 1'b1, gB);
         end
      join
      waitIdle();
      checkOutput("lateReqGap", gB - gA, 32'd4);

      // Reset during WAIT of a read drops the transaction.
      expGnt.push_back(0);
      req0 = 1'b1; wr0 = 1'b0; idx0 = 11'd5;
      waitGnt(0, tmpC);
      req0 = 1'b0;
      @(negedge clk);
      checkOutput("busyInWait", {31'b0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("asyncResetBusy", {31'b0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("postResetIdle", idleWord(), 32'd0);
      end
      applyStimulus(0, 1'b0, 11'd2, 32'd0, 1'b1, g);
      waitIdle();

      // Back-to-back writes from port 1. Grants are exactly two cycles apart.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1'b1, i[IW-1:0], 32'hA5A50000 | i, 1'b1, g);
         if (i > 0) checkOutput("wrSpacing", g - prevG, 32'd2);
         prevG = g;
      end
      waitIdle();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1'b0, i[IW-1:0], 32'd0, 1'b1, g);
      end
      waitIdle();

      repeat (5) @(negedge clk);
      checkOutput("gntQueueEmpty", expGnt.size(), 32'd0);
      checkOutput("rd0QueueEmpty", expRd0.size(), 32'd0);
      checkOutput("rd1QueueEmpty", expRd1.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
